spike_event_fifo: RTL and testbench

SPIKE_EVENT_FIFO -- requirements
Module: spike_event_fifo

---
 rtl/spike_evt_pkg.sv | 34 +++
 rtl/evt_fifo.sv | 80 ++++++++
 rtl/spike_event_fifo.sv | 120 ++++++++++++
 tb/tb_spike_event_fifo.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_evt_pkg.sv
// rtl/spike_evt_pkg.sv - shared constants for the spike event FIFO peripheral
//
// Purpose: register addresses, CTRL/STATUS bit positions, default sizing and
//          the packed STATUS layout used by spike_event_fifo.
// Ports:   none (package).
package spike_evt_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_TS_W  = 8;

    localparam logic [3:0] ADDR_EVENT  = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_WMARK  = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h3;
    localparam logic [3:0] ADDR_TSTAMP = 4'h4;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_CLR_FIFO_BIT = 1;
    localparam int CTRL_CLR_OVF_BIT  = 2;

    localparam int STAT_EN_BIT    = 7;
    localparam int STAT_OVF_BIT   = 6;
    localparam int STAT_FULL_BIT  = 5;
    localparam int STAT_EMPTY_BIT = 4;

    typedef struct packed {
        logic       enable;
        logic       overflow;
        logic       full;
        logic       empty;
        logic [3:0] count;
    } status_t;

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous event FIFO with clear and drop detection
//
// Purpose: stores event timestamps; push/pop/clear with clear highest priority.
// Ports:   clk, rst_n        - clock, asynchronous active-low reset
//          i_push, i_pop     - requests (pop ignored when empty)
//          i_clear           - empties FIFO, overrides push/pop
//          i_data            - data to push
//          o_head            - oldest entry (undefined content when empty)
//          o_count           - occupancy 0..DEPTH
//          o_full, o_empty   - occupancy flags
//          o_drop            - push rejected this cycle because FIFO is full
module evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_drop
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_mem[r_rptr];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_pop_ok  = i_pop && !o_empty && !i_clear;
    assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_clear;
    assign o_drop    = i_push && o_full && !w_pop_ok && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - timestamped spike event queue with register interface
//
// Purpose: timestamps incoming spikes, queues them in evt_fifo, exposes a small
//          register map and a watermark interrupt.
// Ports:   clk, rst_n       - clock, asynchronous active-low reset
//          spike_in         - per-cycle spike flag
//          address          - register address
//          data_write       - write strobe, data_in is write data
//          data_read        - read strobe; at EVENT it pops the FIFO
//          data_out         - combinational read data
//          irq              - watermark interrupt (level)
module spike_event_fifo
    import spike_evt_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spike_in,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    input  logic       data_read,
    output logic [7:0] data_out,
    output logic       irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic            r_enable;
    logic            r_overflow;
    logic [7:0]      r_watermark;
    logic [TS_W-1:0] r_tstamp;

    logic             w_wr_ctrl;
    logic             w_clr_fifo;
    logic             w_clr_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [TS_W-1:0]  w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    status_t          w_status;

    assign w_wr_ctrl  = data_write && (address == ADDR_CTRL);
    assign w_clr_fifo = w_wr_ctrl && data_in[CTRL_CLR_FIFO_BIT];
    assign w_clr_ovf  = w_wr_ctrl && data_in[CTRL_CLR_OVF_BIT];
    assign w_push     = spike_in && r_enable;
    assign w_pop      = data_read && (address == ADDR_EVENT);

    evt_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clr_fifo),
        .i_data  (r_tstamp),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable    <= 1'b0;
            r_overflow  <= 1'b0;
            r_watermark <= 8'h00;
            r_tstamp    <= '0;
        end else begin
            if (r_enable) begin
                r_tstamp <= r_tstamp + TS_W'(1);
            end
            if (data_write && (address == ADDR_WMARK)) begin
                r_watermark <= data_in;
            end
            if (w_wr_ctrl) begin
                r_enable <= data_in[CTRL_EN_BIT];
            end
            // Clearing wins over a drop landing in the same cycle.
            if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Watermark 0 disables the interrupt; values above DEPTH can never be met.
    assign irq = r_enable && (r_watermark != 8'h00) && (8'(w_count) >= r_watermark);

    always_comb begin
        w_status          = '0;
        w_status.enable   = r_enable;
        w_status.overflow = r_overflow;
        w_status.full     = w_full;
        w_status.empty    = w_empty;
        w_status.count    = 4'(w_count);
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_EVENT:  data_out = w_empty ? 8'h00 : 8'(w_head);
            ADDR_STATUS: data_out = w_status;
            ADDR_WMARK:  data_out = r_watermark;
            ADDR_CTRL:   data_out = {7'd0, r_enable};
            ADDR_TSTAMP: data_out = 8'(r_tstamp);
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spike_event_fifo.sv
// tb/tb_spike_event_fifo.sv - scoreboard bench for spike_event_fifo
module tb_spike_event_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spike_in = 1'b0;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_read = 1'b0;
    logic [7:0] data_out;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_ts = 8'h00;
    logic [7:0] m_wm = 8'h00;
    bit         m_en = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_q[$];

    spike_event_fifo #(.DEPTH(DEPTH), .TS_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_read  (data_read),
        .data_out   (data_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_status();
        int n;
        n = m_q.size();
        return {m_en, m_ovf, n == DEPTH, n == 0, 4'(n)};
    endfunction

    function automatic logic exp_irq();
        return m_en && (m_wm != 8'h00) && (8'(m_q.size()) >= m_wm);
    endfunction

    // Advance one clock, updating the reference model from the inputs held before the edge.
    task automatic tick();
        bit push, pop, clr, clro;
        push = spike_in && m_en;
        pop  = data_read && (address == 4'h0) && (m_q.size() != 0);
        clr  = data_write && (address == 4'h3) && data_in[1];
        clro = data_write && (address == 4'h3) && data_in[2];
        if (rst_n) begin
            if (clr) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                    else m_ovf = 1'b1;
                end
            end
            if (clro) m_ovf = 1'b0;
            if (data_write && (address == 4'h2)) m_wm = data_in;
            if (m_en) m_ts = m_ts + 8'd1;
            if (data_write && (address == 4'h3)) m_en = data_in[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        logic [3:0] saved;
        saved = address;
        address = a;
        #1;
        d = data_out;
        address = saved;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts = 8'h00;
        m_wm = 8'h00;
        m_en = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Pop one event, comparing EVENT against the scoreboard head.
    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = (m_q.size() != 0) ? m_q[0] : 8'h00;
        address = 4'h0;
        data_read = 1'b1;
        #1;
        n_vec++;
        if (data_out !== exp) begin
            n_err++;
            $display("FAIL %s event got %h expected %h", name, data_out, exp);
        end
        tick();
        data_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        model_reset();
        #3;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b expected 0", irq); end
        peek(4'h0, d);
        n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL reset_event got %h expected 00", d); end
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'h10) begin n_err++; $display("FAIL reset_status got %h expected 10", d); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        wr(4'h3, 8'h01);
        for (int i = 0; i < 20 && m_ts != 8'h05; i++) tick();
        peek(4'h4, d);
        n_vec++;
        if (d !== 8'h05) begin n_err++; $display("FAIL basic_tstamp got %h expected 05", d); end
        spike_in = 1'b1;
        repeat (3) tick();
        spike_in = 1'b0;
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'h83) begin n_err++; $display("FAIL basic_status got %h expected 83", d); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (m_q[0] !== 8'(5 + i)) begin
                n_err++;
                $display("FAIL basic_order scoreboard head %h expected %h", m_q[0], 8'(5 + i));
            end
            pop_check("basic_pop");
        end
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'h90) begin n_err++; $display("FAIL basic_empty got %h expected 90", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        spike_in = 1'b1;
        repeat (10) tick();
        spike_in = 1'b0;
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'hE8) begin n_err++; $display("FAIL ovf_status got %h expected e8", d); end
        wr(4'h3, 8'h05);
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'hA8) begin n_err++; $display("FAIL ovf_clear got %h expected a8", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, new_ts;
        new_ts = m_ts;
        spike_in = 1'b1;
        pop_check("b2b_pop");
        spike_in = 1'b0;
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'hA8 || d !== exp_status()) begin
            n_err++;
            $display("FAIL b2b_status got %h expected a8", d);
        end
        for (int i = 0; i < DEPTH - 1; i++) pop_check("b2b_drain");
        address = 4'h0;
        #1;
        n_vec++;
        if (data_out !== new_ts) begin n_err++; $display("FAIL b2b_tail got %h expected %h", data_out, new_ts); end
        pop_check("b2b_last");
    endtask

    task automatic test_watermark();
        logic [7:0] d;
        wr(4'h2, 8'h03);
        spike_in = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL wm_two got %b expected 0", irq); end
        tick();
        spike_in = 1'b0;
        n_vec++;
        if (irq !== 1'b1 || irq !== exp_irq()) begin n_err++; $display("FAIL wm_rise got %b expected 1", irq); end
        pop_check("wm_pop");
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL wm_fall got %b expected 0", irq); end
        wr(4'h2, 8'h09);
        spike_in = 1'b1;
        repeat (8) tick();
        spike_in = 1'b0;
        peek(4'h1, d);
        n_vec++;
        if (irq !== 1'b0 || d !== exp_status()) begin
            n_err++;
            $display("FAIL wm_high got irq %b status %h expected 0 %h", irq, d, exp_status());
        end
        wr(4'h3, 8'h07);
        wr(4'h2, 8'h00);
    endtask

    task automatic test_empty_clear();
        logic [7:0] d;
        pop_check("empty_pop");
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'h90) begin n_err++; $display("FAIL empty_status got %h expected 90", d); end
        spike_in = 1'b1;
        tick();
        address = 4'h3;
        data_in = 8'h03;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
        spike_in = 1'b0;
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'h90 || d !== exp_status()) begin
            n_err++;
            $display("FAIL clear_push got %h expected 90", d);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] d;
        for (int i = 0; i < 300 && m_ts != 8'hFF; i++) tick();
        spike_in = 1'b1;
        repeat (2) tick();
        spike_in = 1'b0;
        n_vec++;
        if (m_q.size() != 2 || m_q[0] !== 8'hFF || m_q[1] !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_model size %0d expected ff,00", m_q.size());
        end
        pop_check("wrap_ff");
        pop_check("wrap_00");
        wr(4'h2, 8'h01);
        spike_in = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got %b expected 1", irq); end
        rst_n = 1'b0;
        spike_in = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL midrst_irq got %b expected 0", irq); end
        peek(4'h1, d);
        n_vec++;
        if (d !== 8'h10) begin n_err++; $display("FAIL midrst_status got %h expected 10", d); end
        peek(4'h0, d);
        n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL midrst_event got %h expected 00", d); end
        tick();
        rst_n = 1'b1;
        tick();
        peek(4'h4, d);
        n_vec++;
        if (d !== 8'h00) begin n_err++; $display("FAIL midrst_tstamp got %h expected 00", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_watermark();
        test_empty_clear();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
